// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush sequencer for the 5-stage pipeline
// Load-use stall, branch squash, dmem freeze, debug halt/step FSM, perf counters.
module pipeline_hazard_ctrl #(
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       RS1_ID,
   input  logic [4:0]       RS2_ID,
   input  logic             use_rs1_ID,
   input  logic             use_rs2_ID,
   input  logic [4:0]       RD_EX,
   input  logic             MemRead_EX,
   input  logic             branch_taken_EX,
   input  logic             dmem_req,
   input  logic             dmem_ready,
   input  logic             dbg_halt_req,
   input  logic             dbg_step,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             id_ex_write,
   output logic             ex_mem_write,
   output logic             mem_wb_write,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             halted,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic [1:0] {RUN, MEM_WAIT, HALTED, STEP} state_t;

   localparam logic [15:0] TIMEOUT_VAL = 16'(MEM_TIMEOUT);

   state_t      state;
   state_t      next_state;
   logic [15:0] wait_cnt;
   logic        mem_busy;
   logic        lu_hazard;
   logic        freeze;
   logic        branch_flush;

   assign mem_busy  = dmem_req & ~dmem_ready;
   assign lu_hazard = MemRead_EX & (RD_EX != 5'd0) &
                      ((use_rs1_ID & (RD_EX == RS1_ID)) | (use_rs2_ID & (RD_EX == RS2_ID)));
   assign freeze       = (state == HALTED) | mem_busy;
   assign branch_flush = reset & ~freeze & branch_taken_EX;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= RUN;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         RUN: begin
            if (mem_busy)          next_state = MEM_WAIT;
            else if (dbg_halt_req) next_state = HALTED;
         end
         MEM_WAIT: begin
            if (dmem_ready)        next_state = dbg_halt_req ? HALTED : RUN;
         end
         HALTED: begin
            if (!dbg_halt_req)     next_state = RUN;
            else if (dbg_step)     next_state = STEP;
         end
         STEP: begin
            if (mem_busy)          next_state = MEM_WAIT;
            else if (dbg_halt_req) next_state = HALTED;
            else                   next_state = RUN;
         end
         default:                  next_state = RUN;
      endcase
   end

   // Reset bubbles the whole pipeline; otherwise freeze > branch > load-use > normal.
   always_comb begin
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      id_ex_write  = 1'b1;
      ex_mem_write = 1'b1;
      mem_wb_write = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      if (!reset) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         id_ex_write  = 1'b0;
         ex_mem_write = 1'b0;
         mem_wb_write = 1'b0;
         if_id_flush  = 1'b1;
         id_ex_flush  = 1'b1;
      end else if (freeze) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         id_ex_write  = 1'b0;
         ex_mem_write = 1'b0;
         mem_wb_write = 1'b0;
      end else if (branch_taken_EX) begin
         if_id_flush  = 1'b1;
         id_ex_flush  = 1'b1;
      end else if (lu_hazard) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         id_ex_flush  = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wait_cnt    <= 16'd0;
         halted      <= 1'b0;
         mem_timeout <= 1'b0;
         stall_cnt   <= '0;
         flush_cnt   <= '0;
      end else begin
         if ((state != MEM_WAIT) && (next_state == MEM_WAIT)) begin
            wait_cnt <= 16'd0;
         end else if ((state == MEM_WAIT) && (wait_cnt != 16'hFFFF)) begin
            wait_cnt <= wait_cnt + 16'd1;
         end
         // Sticky: the pipeline keeps waiting, software inspects the flag later.
         if ((state == MEM_WAIT) && (wait_cnt == TIMEOUT_VAL)) begin
            mem_timeout <= 1'b1;
         end
         halted <= (next_state == HALTED);
         if (!pc_write && (state != HALTED)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
         end
         if (branch_flush) begin
            flush_cnt <= flush_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - scoreboard bench for pipeline_hazard_ctrl
// Directed test-plan sequences then random stimulus against a behavioural model.
module tb_pipeline_hazard_ctrl;

   localparam int TMO = 3;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [4:0]  RS1_ID = '0, RS2_ID = '0, RD_EX = '0;
   logic        use_rs1_ID = 0, use_rs2_ID = 0, MemRead_EX = 0, branch_taken_EX = 0;
   logic        dmem_req = 0, dmem_ready = 0, dbg_halt_req = 0, dbg_step = 0;
   logic        pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write;
   logic        if_id_flush, id_ex_flush, halted, mem_timeout;
   logic [31:0] stall_cnt, flush_cnt;

   pipeline_hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(32)) dut (
      .clk(clk), .reset(reset),
      .RS1_ID(RS1_ID), .RS2_ID(RS2_ID), .use_rs1_ID(use_rs1_ID), .use_rs2_ID(use_rs2_ID),
      .RD_EX(RD_EX), .MemRead_EX(MemRead_EX), .branch_taken_EX(branch_taken_EX),
      .dmem_req(dmem_req), .dmem_ready(dmem_ready),
      .dbg_halt_req(dbg_halt_req), .dbg_step(dbg_step),
      .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_write(id_ex_write),
      .ex_mem_write(ex_mem_write), .mem_wb_write(mem_wb_write),
      .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
      .halted(halted), .mem_timeout(mem_timeout),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [6:0]  ctl;   // {pc, if_id, id_ex, ex_mem, mem_wb, if_id_flush, id_ex_flush}
      logic        hlt;
      logic        tmo;
      logic [31:0] stl;
      logic [31:0] fls;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;

   // Reference model: mode flags and counters.
   bit          m_halted, m_waiting, m_tmo;
   int          m_wait_k;
   logic [31:0] m_stall, m_flush;

   task automatic model_reset();
      m_halted = 0; m_waiting = 0; m_tmo = 0; m_wait_k = 0;
      m_stall = 0; m_flush = 0;
   endtask

   task automatic cyc(input logic [4:0] r1, input logic [4:0] r2, input bit u1, input bit u2,
                      input logic [4:0] rd, input bit mr, input bit br,
                      input bit req, input bit rdy, input bit hr, input bit st);
      exp_t e;
      bit   busy, lu;
      @(negedge clk);
      reset = 1; RS1_ID = r1; RS2_ID = r2; use_rs1_ID = u1; use_rs2_ID = u2;
      RD_EX = rd; MemRead_EX = mr; branch_taken_EX = br;
      dmem_req = req; dmem_ready = rdy; dbg_halt_req = hr; dbg_step = st;
      busy = req && !rdy;
      lu = mr && (rd != 0) && ((u1 && rd == r1) || (u2 && rd == r2));
      if (m_halted || busy)  e.ctl = 7'b00000_00;
      else if (br)           e.ctl = 7'b11111_11;
      else if (lu)           e.ctl = 7'b00111_01;
      else                   e.ctl = 7'b11111_00;
      e.hlt = m_halted; e.tmo = m_tmo; e.stl = m_stall; e.fls = m_flush;
      exp_q.push_back(e);
      if (!e.ctl[6] && !m_halted) m_stall++;
      if (!m_halted && !busy && br) m_flush++;
      if (m_waiting) begin
         if (m_wait_k == TMO) m_tmo = 1;
         m_wait_k++;
         if (rdy) begin
            m_waiting = 0;
            m_halted = hr;
         end
      end else if (m_halted) begin
         if (!hr || st) m_halted = 0;   // leaving to RUN or a STEP cycle, both behave as run
      end else if (busy) begin
         m_waiting = 1;
         m_wait_k = 0;
      end else begin
         m_halted = hr;
      end
   endtask

   task automatic plain(input bit req, input bit rdy, input bit hr, input bit st);
      cyc(5'd1, 5'd2, 0, 0, 5'd0, 0, 0, req, rdy, hr, st);
   endtask

   task automatic apply_reset(input int n);
      exp_t e;
      e.ctl = 7'b00000_11; e.hlt = 0; e.tmo = 0; e.stl = 0; e.fls = 0;
      @(negedge clk);
      reset = 0;
      model_reset();
      exp_q.push_back(e);
      for (int i = 1; i < n; i++) begin
         @(negedge clk);
         exp_q.push_back(e);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if ({pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
                 if_id_flush, id_ex_flush} !== e.ctl) begin
               fails++;
               $display("FAIL ctl t=%0t got %b want %b", $time,
                        {pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
                         if_id_flush, id_ex_flush}, e.ctl);
            end
            tests++;
            if (halted !== e.hlt) begin
               fails++;
               $display("FAIL halted t=%0t got %b want %b", $time, halted, e.hlt);
            end
            tests++;
            if (mem_timeout !== e.tmo) begin
               fails++;
               $display("FAIL mem_timeout t=%0t got %b want %b", $time, mem_timeout, e.tmo);
            end
            tests++;
            if (stall_cnt !== e.stl) begin
               fails++;
               $display("FAIL stall_cnt t=%0t got %0d want %0d", $time, stall_cnt, e.stl);
            end
            tests++;
            if (flush_cnt !== e.fls) begin
               fails++;
               $display("FAIL flush_cnt t=%0t got %0d want %0d", $time, flush_cnt, e.fls);
            end
         end
      end
   end

   initial begin : driver
      bit hr;
      apply_reset(3);
      // load-use stall, then same with x0 destination
      cyc(5'd5, 5'd9, 1, 0, 5'd5, 1, 0, 0, 0, 0, 0);
      cyc(5'd0, 5'd9, 1, 0, 5'd0, 1, 0, 0, 0, 0, 0);
      // branch together with load-use
      cyc(5'd5, 5'd7, 1, 1, 5'd7, 1, 1, 0, 0, 0, 0);
      // four frozen cycles then release
      repeat (4) plain(1, 0, 0, 0);
      plain(1, 1, 0, 0);
      plain(0, 0, 0, 0);
      // long wait trips the timeout
      repeat (5) plain(1, 0, 0, 0);
      plain(1, 1, 0, 0);
      repeat (2) plain(0, 0, 0, 0);
      // halt requested mid-access, then a single step
      repeat (3) plain(1, 0, 1, 0);
      plain(1, 1, 1, 0);
      repeat (2) plain(0, 0, 1, 0);
      plain(0, 0, 1, 1);
      repeat (3) plain(0, 0, 1, 0);
      plain(0, 0, 0, 0);
      plain(0, 0, 0, 0);
      // reset asserted in the middle of a wait
      repeat (2) plain(1, 0, 0, 0);
      apply_reset(2);
      plain(0, 0, 0, 0);
      cyc(5'd3, 5'd3, 0, 1, 5'd3, 1, 0, 0, 0, 0, 0);

      hr = 0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 24) == 0) hr = !hr;
         if ($urandom_range(0, 399) == 0) begin
            apply_reset($urandom_range(1, 3));
         end else begin
            cyc(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                5'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 5) == 0),
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                hr, ($urandom_range(0, 3) == 0));
         end
      end
      plain(0, 0, 0, 0);
      @(negedge clk);
      #4;
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL scoreboard_drain got %0d want 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush sequencer for the 5-stage RISC-V pipeline. Drives the write enables and bubble/flush controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It detects load-use hazards, squashes wrong-path instructions on taken branches, freezes the pipeline while data memory is busy, and provides a debug halt/single-step state machine. Stall and flush performance counters are included.

## Interface
Parameters:
- MEM_TIMEOUT, 255: MEM_WAIT cycles after which mem_timeout is set (1..65535).
- CNT_W, 32: width of stall_cnt / flush_cnt.

Ports:
- clk  in  1  pipeline clock; all state changes on the rising edge.
- reset  in  1  reset, asynchronous, active-low.
- RS1_ID, RS2_ID  in  5  source registers of the instruction in ID.
- use_rs1_ID, use_rs2_ID  in  1  the ID instruction actually reads rs1 / rs2.
- RD_EX  in  5  destination register of the instruction in EX.
- MemRead_EX  in  1  the EX instruction is a load.
- branch_taken_EX  in  1  the EX instruction redirects the PC this cycle.
- dmem_req  in  1  the MEM stage has an access outstanding.
- dmem_ready  in  1  data memory completes the access this cycle.
- dbg_halt_req  in  1  level request to halt the pipeline.
- dbg_step  in  1  one-cycle pulse; advances one pipeline cycle while halted.
- pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write  out  1  register write enables.
- if_id_flush, id_ex_flush  out  1  load a bubble (all zero) into IF/ID / ID/EX at the next edge; overrides the write enable.
- halted  out  1  registered; 1 while in HALTED.
- mem_timeout  out  1  sticky error flag.
- stall_cnt, flush_cnt  out  CNT_W  performance counters.

## Operation
- Terms:
  - mem_busy = dmem_req & ~dmem_ready.
  - lu_hazard = MemRead_EX & (RD_EX != 0) & ((use_rs1_ID & RD_EX == RS1_ID) | (use_rs2_ID & RD_EX == RS2_ID)).
- Control outputs are combinational from state and inputs. Priority, highest first:
  1. Freeze (state HALTED, or mem_busy in any state): all write enables 0, both flushes 0. A taken branch is deferred; it stays in EX and acts on the release cycle.
  2. Branch (branch_taken_EX): if_id_flush = 1, id_ex_flush = 1, all write enables 1.
  3. Load-use (lu_hazard): pc_write = 0, if_id_write = 0, id_ex_flush = 1; ex_mem_write = 1, mem_wb_write = 1.
  4. Normal: all write enables 1, flushes 0.
- When branch and load-use occur together, the branch wins; the stalled ID instruction is squashed.
- FSM states: RUN, MEM_WAIT, HALTED, STEP.
  - RUN: mem_busy → MEM_WAIT; else dbg_halt_req → HALTED; else stay.
  - MEM_WAIT: dmem_ready → HALTED if dbg_halt_req, else RUN; otherwise stay.
  - HALTED: ~dbg_halt_req → RUN; else dbg_step → STEP; else stay. dmem inputs are ignored here, because no MEM-stage access is launched while halted.
  - STEP: one normal cycle with priorities 2–4 active. mem_busy → MEM_WAIT; else → HALTED (→ RUN if dbg_halt_req has dropped).
  - A halt is never entered mid-access; an outstanding access always completes first.
- Timeout:
  - wait_cnt is 16 bits, internal. It clears on entry to MEM_WAIT and increments each cycle in MEM_WAIT, saturating at 65535.
  - When wait_cnt == MEM_TIMEOUT, mem_timeout sets and stays 1 until reset. The pipeline keeps waiting.
- Counters:
  - stall_cnt +1 in each cycle where pc_write == 0 and state != HALTED.
  - flush_cnt +1 in each cycle where a branch flush is issued.
  - Both wrap modulo 2^CNT_W.

## Timing
- Reset (reset = 0, asynchronous): state = RUN, wait_cnt = 0, halted = 0, mem_timeout = 0, stall_cnt = 0, flush_cnt = 0.
  - While reset is low, all write enables are 0 and both flushes are 1 (the pipeline is bubbled).
  - Reset release is synchronised externally; the first edge after release behaves as RUN.
- Hazard outputs have zero latency: they respond in the same cycle as their inputs.
- halted rises one edge after the halt decision. With dbg_halt_req held from cycle N in RUN with no mem_busy, cycle N is a normal cycle and halted = 1 from cycle N+1.
- dbg_step pulse in HALTED at cycle N: cycle N+1 is the STEP cycle (exactly one advance), and halted = 1 again at N+2.
- The release cycle out of MEM_WAIT (dmem_ready = 1) is an unfrozen cycle; priorities 2–4 apply in it.
- If reset is asserted mid-wait or while halted, the block returns to RUN immediately and the counters clear.

## Test plan
- Load-use: MemRead_EX = 1, RD_EX = 5, RS1_ID = 5, use_rs1_ID = 1 for one cycle → pc_write = 0, if_id_write = 0, id_ex_flush = 1 that cycle; stall_cnt 0 → 1. Repeat with RD_EX = 0 → no stall.
- Branch + load-use in the same cycle → if_id_flush = 1, id_ex_flush = 1, pc_write = 1; flush_cnt = 1, stall_cnt unchanged.
- dmem_req = 1 with dmem_ready low for 4 cycles, then high → 4 frozen cycles (all enables 0), release cycle normal; stall_cnt += 4.
- With MEM_TIMEOUT = 3, hold mem_busy 5 cycles → mem_timeout rises during the wait and stays 1 after dmem_ready, until reset is pulsed low.
- Raise dbg_halt_req during mem_busy → no HALTED until dmem_ready; halted = 1 the cycle after completion. Then one dbg_step pulse → exactly one cycle with pc_write = 1, after which halted = 1.
- Assert reset low while in MEM_WAIT → halted = 0, counters = 0, flushes = 1 asynchronously; after release, normal operation.
